vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_timing_gen_if.sv | 28 ++
 rtl/vga_axis_counter.sv | 60 ++++++
 rtl/vga_timing_gen.sv | 82 ++++++++
 tb/tb_vga_timing_gen.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing types and standard mode presets for the VGA timing generator.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        h_pol;
    logic        v_pol;
  } timing_t;

  localparam timing_t VGA_640x480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
    h_pol: 1'b0, v_pol: 1'b0
  };

  localparam timing_t SVGA_800x600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    h_pol: 1'b1, v_pol: 1'b1
  };

  localparam timing_t XGA_1024x768_60 = '{
    h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
    v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29,
    h_pol: 1'b0, v_pol: 1'b0
  };

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-advance enable in, raster position and sync/blanking outputs back.
interface vga_timing_gen_if #(
    parameter int unsigned CW = 10,
    parameter int unsigned FW = 8
);
    logic          ce;
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          h_sync;
    logic          v_sync;
    logic          display_en;
    logic          vblank;
    logic          line_start;
    logic          frame_start;
    logic [FW-1:0] frame_count;

    modport master (
        input  ce,
        output h_count, v_count, h_sync, v_sync, display_en, vblank,
        output line_start, frame_start, frame_count
    );

    modport slave (
        output ce,
        input  h_count, v_count, h_sync, v_sync, display_en, vblank,
        input  line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with sync and active decode registered
// from the next count so they stay aligned with the count itself.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48,
    parameter bit          POL    = 1'b0,
    parameter int unsigned CW     = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          wrap_in,
    output logic [CW-1:0] count,
    output logic          sync,
    output logic          active,
    output logic          wrap_out
);

    localparam int unsigned   TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int unsigned   SYNC_START = ACTIVE + FP;
    localparam int unsigned   SYNC_END   = ACTIVE + FP + SYNC;
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);

    if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0 ||
        ((64'(TOTAL) - 64'd1) >> CW) != 64'd0) begin : g_bad_params
        $error("vga_axis_counter: zero region or total does not fit in CW bits");
    end

    logic [CW-1:0] count_d;
    logic          sync_d;
    logic          active_d;

    assign wrap_out = wrap_in && (count == LAST);

    always_comb begin
        count_d = count;
        if (ce && wrap_in) begin
            count_d = (count == LAST) ? '0 : count + 1'b1;
        end
        sync_d   = (32'(count_d) >= SYNC_START && 32'(count_d) < SYNC_END) ? POL : ~POL;
        active_d = 32'(count_d) < ACTIVE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= LAST;
            sync   <= ~POL;
            active <= 1'b0;
        end else begin
            count  <= count_d;
            sync   <= sync_d;
            active <= active_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal and vertical axis counters plus registered
// display enable, line/frame strobes and a wrapping frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned CW       = 10,
    parameter int unsigned FW       = 8
) (
    input logic              clk,
    input logic              reset,
    vga_timing_gen_if.master bus
);

    logic [CW-1:0] h_count, v_count;
    logic          h_sync, v_sync, h_active, v_active, h_wrap, v_wrap;
    logic          h_act_nxt, v_act_nxt;
    logic          display_en_d, display_en_q;
    logic          line_start_q, frame_start_q;
    logic [FW-1:0] frame_count_q;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CW(CW)
    ) u_h_axis (
        .clk(clk), .reset(reset), .ce(bus.ce), .wrap_in(1'b1),
        .count(h_count), .sync(h_sync), .active(h_active), .wrap_out(h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CW(CW)
    ) u_v_axis (
        .clk(clk), .reset(reset), .ce(bus.ce), .wrap_in(h_wrap),
        .count(v_count), .sync(v_sync), .active(v_active), .wrap_out(v_wrap)
    );

    // Active region starts each axis, so a wrap always lands inside it.
    always_comb begin
        h_act_nxt = h_wrap || (h_active && (32'(h_count) + 32'd1 < H_ACTIVE));
        v_act_nxt = h_wrap ? (v_wrap || (v_active && (32'(v_count) + 32'd1 < V_ACTIVE)))
                           : v_active;
        display_en_d = display_en_q;
        if (bus.ce) begin
            display_en_d = h_act_nxt && v_act_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            display_en_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '1;
        end else begin
            display_en_q  <= display_en_d;
            line_start_q  <= bus.ce && h_wrap;
            frame_start_q <= bus.ce && v_wrap;
            if (bus.ce && v_wrap) begin
                frame_count_q <= frame_count_q + 1'b1;
            end
        end
    end

    assign bus.h_count     = h_count;
    assign bus.v_count     = v_count;
    assign bus.h_sync      = h_sync;
    assign bus.v_sync      = v_sync;
    assign bus.display_en  = display_en_q;
    assign bus.vblank      = ~v_active;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen; expected raster state is derived from the
// number of accepted pixel advances since reset.
module tb_vga_timing_gen;

    localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(10), .FW(8)) bus0 ();
    vga_timing_gen_if #(.CW(10), .FW(8)) bus1 ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .CW(10), .FW(8)
    ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b0), .CW(10), .FW(8)
    ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    logic [9:0] hc[2], vc[2];
    logic [7:0] fc[2];
    logic       hs[2], vs[2], de[2], vb[2], ls[2], fs[2];

    assign hc[0] = bus0.h_count;     assign hc[1] = bus1.h_count;
    assign vc[0] = bus0.v_count;     assign vc[1] = bus1.v_count;
    assign hs[0] = bus0.h_sync;      assign hs[1] = bus1.h_sync;
    assign vs[0] = bus0.v_sync;      assign vs[1] = bus1.v_sync;
    assign de[0] = bus0.display_en;  assign de[1] = bus1.display_en;
    assign vb[0] = bus0.vblank;      assign vb[1] = bus1.vblank;
    assign ls[0] = bus0.line_start;  assign ls[1] = bus1.line_start;
    assign fs[0] = bus0.frame_start; assign fs[1] = bus1.frame_start;
    assign fc[0] = bus0.frame_count; assign fc[1] = bus1.frame_count;

    int          checks = 0;
    int          errors = 0;
    int unsigned n_ce   = 0;
    bit          last_ce = 1'b0;
    int unsigned h_e, v_e, fc_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: raster position is simply (advances - 1) laid out row-major.
    task automatic check_all();
        int unsigned p;
        bit de_e, vb_e, hs_act, vs_act, ls_e, fs_e;
        string pre;
        if (n_ce == 0) begin
            h_e = HT - 1; v_e = VT - 1; fc_e = 255;
        end else begin
            p = n_ce - 1;
            h_e = p % HT; v_e = (p / HT) % VT; fc_e = (p / FRAME) % 256;
        end
        de_e   = (h_e < HA) && (v_e < VA);
        vb_e   = v_e >= VA;
        hs_act = (h_e >= HA + HF) && (h_e < HA + HF + HS);
        vs_act = (v_e >= VA + VF) && (v_e < VA + VF + VS);
        ls_e   = last_ce && (n_ce > 0) && (h_e == 0);
        fs_e   = ls_e && (v_e == 0);
        for (int i = 0; i < 2; i++) begin
            pre = (i == 0) ? "d0." : "d1.";
            check({pre, "h_count"},     32'(hc[i]), h_e);
            check({pre, "v_count"},     32'(vc[i]), v_e);
            check({pre, "h_sync"},      32'(hs[i]), 32'((i == 1) ? hs_act : !hs_act));
            check({pre, "v_sync"},      32'(vs[i]), 32'(!vs_act));
            check({pre, "display_en"},  32'(de[i]), 32'(de_e));
            check({pre, "vblank"},      32'(vb[i]), 32'(vb_e));
            check({pre, "line_start"},  32'(ls[i]), 32'(ls_e));
            check({pre, "frame_start"}, 32'(fs[i]), 32'(fs_e));
            check({pre, "frame_count"}, 32'(fc[i]), fc_e);
        end
    endtask

    task automatic tick(input bit c);
        bus0.ce = c;
        bus1.ce = c;
        @(posedge clk);
        if (!reset && c) n_ce++;
        last_ce = c && !reset;
        #1 check_all();
    endtask

    int fs_cnt, ls_cnt, iter;
    logic [7:0] fc_prev;

    initial begin
        bus0.ce = 1'b0;
        bus1.ce = 1'b0;
        reset   = 1'b1;
        #1 check_all();
        tick(1'b0);
        tick(1'b1);
        reset = 1'b0;

        // Full-rate run: frame_start every FRAME clocks.
        fs_cnt = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick(1'b1);
            if (fs[0]) fs_cnt++;
        end
        check("frame_starts_in_3_frames", 32'(fs_cnt), 3);

        // One advance in four: strobes remain single-clock.
        ls_cnt = 0;
        for (int k = 0; k < 4 * 4 * HT; k++) begin
            tick(k % 4 == 0);
            if (ls[0]) ls_cnt++;
        end
        check("line_start_clks_1in4", 32'(ls_cnt), 4);

        for (int k = 0; k < 400; k++) tick(1'($urandom_range(0, 1)));

        // Run to h=5,v=2 then reset between clock edges.
        iter = 0;
        while (!(h_e == 5 && v_e == 2) && iter < 2 * FRAME) begin
            tick(1'b1);
            iter++;
        end
        check("reached_h5_v2", 32'(h_e * 16 + v_e), 5 * 16 + 2);
        #1 reset = 1'b1;
        n_ce    = 0;
        last_ce = 1'b0;
        #1 check_all();
        check("async_rst_frame_count", 32'(fc[0]), 255);
        tick(1'b1);
        tick(1'b1);
        reset = 1'b0;

        // Long random run across the 8-bit frame counter wrap.
        iter    = 0;
        fc_prev = fc[1];
        while (n_ce < 256 * FRAME + 1 && iter < 40000) begin
            fc_prev = fc[1];
            tick($urandom_range(0, 7) != 0);
            iter++;
        end
        check("wrap_reached", n_ce, 256 * FRAME + 1);
        check("fc_before_wrap", 32'(fc_prev), 255);
        check("fc_after_wrap", 32'(fc[1]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
